// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: collects A/B/opcode bytes for the alu and hands its result
// to a byte transmitter over valid/ready, with an inter-byte command timeout.
module alu_cmd_sequencer #(
   parameter int N_BITS         = 8,
   parameter int OP_BITS        = 6,
   parameter int TIMEOUT_CYCLES = 100000000
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [N_BITS-1:0]  rx_data,
   input  logic               rx_valid,
   output logic [N_BITS-1:0]  d0,
   output logic [N_BITS-1:0]  d1,
   output logic [OP_BITS-1:0] opcode,
   input  logic [N_BITS-1:0]  alu_out,
   output logic [N_BITS-1:0]  tx_data,
   output logic               tx_valid,
   input  logic               tx_ready,
   output logic               busy,
   output logic               err
);
   localparam int CW = TIMEOUT_CYCLES == 0 ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES == 0 ? 0 : TIMEOUT_CYCLES - 1);
   typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND} state_t;
   state_t state, state_nx;
   logic [N_BITS-1:0] d0_nx, d1_nx, tx_data_nx;
   logic [OP_BITS-1:0] opcode_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic tx_valid_nx, err_nx, busy_nx, expire;
   assign expire = (TIMEOUT_CYCLES != 0) && (cnt == LAST) && !rx_valid;
   always_comb begin
      state_nx    = state;
      d0_nx       = d0;
      d1_nx       = d1;
      opcode_nx   = opcode;
      tx_data_nx  = tx_data;
      tx_valid_nx = tx_valid;
      err_nx      = 1'b0;
      cnt_nx      = '0;
      case (state)
         WAIT_A: if (rx_valid) begin
            d0_nx    = rx_data;
            state_nx = WAIT_B;
         end
         WAIT_B, WAIT_OP: if (rx_valid) begin
            if (state == WAIT_B) d1_nx = rx_data;
            else opcode_nx = rx_data[OP_BITS-1:0];
            state_nx = state == WAIT_B ? WAIT_OP : EXEC;
         end else if (expire) begin
            state_nx  = WAIT_A;
            d0_nx     = '0;
            d1_nx     = '0;
            opcode_nx = '0;
            err_nx    = 1'b1;
         end else begin
            cnt_nx = TIMEOUT_CYCLES == 0 ? '0 : cnt + CW'(1);
         end
         EXEC: begin
            tx_data_nx  = alu_out;
            tx_valid_nx = 1'b1;
            state_nx    = SEND;
         end
         SEND: if (tx_ready) begin
            tx_valid_nx = 1'b0;
            state_nx    = WAIT_A;
         end
         default: begin
            tx_valid_nx = 1'b0;
            state_nx    = WAIT_A;
         end
      endcase
      busy_nx = (state_nx == EXEC) || (state_nx == SEND);
   end
   // busy is registered from the next-state decode so it never glitches
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= WAIT_A;
         d0       <= '0;
         d1       <= '0;
         opcode   <= '0;
         tx_data  <= '0;
         tx_valid <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
         cnt      <= '0;
      end else begin
         state    <= state_nx;
         d0       <= d0_nx;
         d1       <= d1_nx;
         opcode   <= opcode_nx;
         tx_data  <= tx_data_nx;
         tx_valid <= tx_valid_nx;
         busy     <= busy_nx;
         err      <= err_nx;
         cnt      <= cnt_nx;
      end
   end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed stimulus, command-level reference model and
// literal checks for alu_cmd_sequencer with a 16-cycle timeout.
module tb_alu_cmd_sequencer;
   localparam int TO = 16;
   logic clk = 0;
   logic rst_n = 1;
   logic [7:0] rx_data = 0;
   logic rx_valid = 0;
   logic tx_ready = 1;
   logic [7:0] d0, d1, alu_out, tx_data;
   logic [5:0] opcode;
   logic tx_valid, busy, err;
   int checks = 0;
   int failures = 0;
   bit go = 0;

   function automatic logic [7:0] alu_f(logic [7:0] a, logic [7:0] b, logic [5:0] op);
      case (op)
         6'h20: return a + b;
         6'h22: return a - b;
         6'h24: return a & b;
         6'h25: return a | b;
         6'h26: return a ^ b;
         6'h27: return ~(a | b);
         default: return 8'h00;
      endcase
   endfunction

   assign alu_out = alu_f(d0, d1, opcode);

   alu_cmd_sequencer #(.N_BITS(8), .OP_BITS(6), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .d0(d0), .d1(d1), .opcode(opcode), .alu_out(alu_out),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Model: count bytes of the current command, idle cycles since the last one,
   // and whether a result is being computed or waiting for the transmitter.
   int m_n = 0, m_idle = 0;
   logic [7:0] m_a = 0, m_b = 0, m_txd = 0;
   logic [5:0] m_op = 0;
   bit m_exec = 0, m_txv = 0, m_err = 0;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_n = 0; m_idle = 0; m_a = 0; m_b = 0; m_op = 0; m_txd = 0;
         m_exec = 0; m_txv = 0; m_err = 0;
      end else begin
         m_err = 0;
         if (m_exec) begin
            m_txd = alu_f(m_a, m_b, m_op);
            m_txv = 1;
            m_exec = 0;
         end else if (m_txv) begin
            if (tx_ready) m_txv = 0;
         end else if (rx_valid) begin
            if (m_n == 0) m_a = rx_data;
            else if (m_n == 1) m_b = rx_data;
            else m_op = rx_data[5:0];
            m_n++;
            m_idle = 0;
            if (m_n == 3) begin
               m_n = 0;
               m_exec = 1;
            end
         end else if (m_n > 0) begin
            m_idle++;
            if (m_idle == TO) begin
               m_n = 0; m_idle = 0; m_a = 0; m_b = 0; m_op = 0; m_err = 1;
            end
         end
      end
   end

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", n, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (go) begin
      chk("m_d0", d0, m_a);
      chk("m_d1", d1, m_b);
      chk("m_opcode", opcode, m_op);
      chk("m_tx_valid", tx_valid, m_txv);
      if (m_txv) chk("m_tx_data", tx_data, m_txd);
      chk("m_busy", busy, m_exec | m_txv);
      chk("m_err", err, m_err);
   end

   // Called #1 after a rising edge; the byte is taken at the next edge.
   task automatic send(logic [7:0] b);
      rx_data = b;
      rx_valid = 1;
      @(posedge clk); #1;
      rx_valid = 0;
   endtask

   task automatic result(logic [7:0] exp);
      @(negedge clk);
      chk("exec_tx_valid", tx_valid, 0);
      chk("exec_busy", busy, 1);
      @(negedge clk);
      chk("send_tx_valid", tx_valid, 1);
      chk("send_tx_data", tx_data, exp);
      @(negedge clk);
      chk("done_tx_valid", tx_valid, 0);
      chk("done_busy", busy, 0);
      @(posedge clk); #1;
   endtask

   task automatic cmd(logic [7:0] a, logic [7:0] b, logic [7:0] op, logic [7:0] exp);
      send(a); send(b); send(op);
      chk("cmd_d0", d0, a);
      chk("cmd_d1", d1, b);
      chk("cmd_opcode", opcode, op[5:0]);
      result(exp);
   endtask

   task automatic reset_zero(string n);
      chk({n, "_d0"}, d0, 0);
      chk({n, "_d1"}, d1, 0);
      chk({n, "_opcode"}, opcode, 0);
      chk({n, "_tx_data"}, tx_data, 0);
      chk({n, "_tx_valid"}, tx_valid, 0);
      chk({n, "_busy"}, busy, 0);
      chk({n, "_err"}, err, 0);
   endtask

   initial begin
      #2 rst_n = 0;
      #1 reset_zero("por");
      #20 rst_n = 1;
      @(posedge clk); #1;
      go = 1;
      cmd(8'h05, 8'h03, 8'h20, 8'h08);
      cmd(8'h03, 8'h05, 8'h22, 8'hFE);
      cmd(8'hF0, 8'h0F, 8'hE7, 8'h00);
      cmd(8'h01, 8'h02, 8'h3F, 8'h00);
      // Stalled transmitter with a stray byte arriving during SEND
      tx_ready = 0;
      send(8'h05); send(8'h03); send(8'h20);
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            rx_data = 8'hAA;
            rx_valid = 1;
         end
         @(negedge clk);
         chk("hold_tx_valid", tx_valid, 1);
         chk("hold_tx_data", tx_data, 8'h08);
         chk("hold_busy", busy, 1);
         @(posedge clk); #1;
         rx_valid = 0;
      end
      tx_ready = 1;
      @(posedge clk); #1;
      cmd(8'h01, 8'h01, 8'h20, 8'h02);
      // Timeout: 16 idle edges after the accept edge
      send(8'h05);
      repeat (TO - 1) @(posedge clk);
      #1 chk("to_pre_err", err, 0);
      chk("to_pre_d0", d0, 8'h05);
      @(posedge clk); #1;
      chk("to_err", err, 1);
      chk("to_d0", d0, 0);
      @(posedge clk); #1;
      chk("to_err_clear", err, 0);
      // Byte in the expiry cycle is accepted
      send(8'h05);
      repeat (TO - 1) @(posedge clk);
      #1 send(8'h03);
      chk("exp_err", err, 0);
      chk("exp_d1", d1, 8'h03);
      send(8'h20);
      result(8'h08);
      // Async reset in WAIT_OP
      send(8'h0C); send(8'h0A);
      #2 rst_n = 0;
      #1 reset_zero("rst_op");
      #3 rst_n = 1;
      @(posedge clk); #1;
      // Async reset in SEND with a pending result
      tx_ready = 0;
      send(8'h05); send(8'h03); send(8'h20);
      @(posedge clk); #1;
      chk("pre_rst_tx_valid", tx_valid, 1);
      #2 rst_n = 0;
      #1 reset_zero("rst_send");
      #3 rst_n = 1;
      tx_ready = 1;
      @(posedge clk); #1;
      cmd(8'h0C, 8'h0A, 8'h24, 8'h08);
      repeat (3) @(posedge clk);
      go = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream/downstream glue stage for the combinational alu (d0, d1, opcode -> out).
- Collects a three-byte command from a byte stream (UART receiver side): operand A, operand B, opcode.
- Drives the alu inputs from registers, captures the alu result, and hands it to a byte transmitter through a valid/ready handshake.
- Sits between the UART rx/tx pair and the alu in the board top level.

Parameters:
N_BITS, 8, data/operand width; must equal the alu N_BITS; must be >= 6.
OP_BITS, 6, opcode width driven to the alu.
TIMEOUT_CYCLES, 100000000, max idle cycles between bytes of one command; 0 disables timeout.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
rx_data  input  N_BITS  received byte.
rx_valid  input  1  single-cycle strobe: rx_data valid this cycle; no backpressure.
d0  output  N_BITS  operand A to alu (registered).
d1  output  N_BITS  operand B to alu (registered).
opcode  output  OP_BITS  opcode to alu (registered).
alu_out  input  N_BITS  alu result (combinational from d0/d1/opcode).
tx_data  output  N_BITS  result byte to transmitter (registered).
tx_valid  output  1  result available; held until accepted.
tx_ready  input  1  transmitter can accept; transfer when tx_valid & tx_ready at rising edge.
busy  output  1  high in EXEC and SEND.
err  output  1  one-cycle pulse on command timeout.

Behaviour:
- Reset (async assert, sync release): state WAIT_A; d0, d1, opcode, tx_data = 0; tx_valid, busy, err = 0; timeout counter = 0.
- States: WAIT_A -> WAIT_B -> WAIT_OP -> EXEC -> SEND -> WAIT_A.
- WAIT_A: on rx_valid, d0 <= rx_data; go to WAIT_B.
- WAIT_B: on rx_valid, d1 <= rx_data; go to WAIT_OP.
- WAIT_OP: on rx_valid, opcode <= rx_data[OP_BITS-1:0] (upper bits ignored); go to EXEC.
- EXEC: lasts exactly 1 cycle. tx_data <= alu_out, tx_valid <= 1; go to SEND.
- SEND: tx_valid held high, tx_data stable. On tx_valid & tx_ready: tx_valid <= 0; go to WAIT_A.
- Latency: opcode byte accepted at edge k; EXEC during cycle k..k+1; tx_valid high after edge k+1. With tx_ready held high, tx_valid is high for exactly 1 cycle.
- rx_valid in EXEC or SEND: byte dropped; no state change.
- Timeout counter, active only in WAIT_B and WAIT_OP:
  - Cleared on every accepted byte and in all other states.
  - Increments each cycle without rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, the next edge returns to WAIT_A, clears d0/d1/opcode to 0, and pulses err for 1 cycle.
  - rx_valid in the expiry cycle wins: the byte is accepted and no err is raised.
  - Counter width is $clog2(TIMEOUT_CYCLES+1). TIMEOUT_CYCLES=0 means the counter is never active.
- d0/d1/opcode keep their values after SEND until overwritten. The alu keeps computing on them, but tx_data is not updated outside EXEC.
- busy = (state==EXEC) | (state==SEND), registered/decoded without glitches from state.
- Reset asserted mid-operation (any state) returns immediately to reset values; a pending tx_valid is dropped.
- Illegal state encodings recover to WAIT_A on the next edge.

Test Plan:
- Bytes 0x05, 0x03, 0x20 with rx_valid strobes, tx_ready=1 -> d0=0x05, d1=0x03, opcode=0x20; tx_data=0x08, tx_valid high 1 cycle, 1 edge after the opcode-accept edge.
- Bytes 0x03, 0x05, 0x22 (sub) -> tx_data=0xFE. Bytes 0xF0, 0x0F, 0xE7 (upper bits ignored, opcode 0x27, nor) -> tx_data=0x00. Opcode byte 0x3F (invalid) -> tx_data=0x00.
- tx_ready=0 for 10 cycles after tx_valid rises -> tx_valid and tx_data=0x08 stable and busy=1 throughout. Extra rx byte 0xAA during SEND is dropped: the next command 0x01, 0x01, 0x20 yields 0x02.
- TIMEOUT_CYCLES=16; send 0x05, then nothing -> err pulses 1 cycle 16 cycles after the accept edge; state WAIT_A, d0=0. Repeat with a byte arriving exactly in the expiry cycle -> accepted as B, no err.
- Assert rst_n=0 asynchronously (mid-clock) in WAIT_OP and again in SEND with tx_ready=0 -> outputs go to reset values immediately. After release, a full command 0x0C, 0x0A, 0x24 gives tx_data=0x08.
